// File: rtl/aes_ks_pkg.sv
// Shared types and helpers for the sequential AES key schedule.
// Key-size encodings, FSM state, Nk/Nr lookup, store depth and GF(2^8) xtime.
package aes_ks_pkg;

  typedef enum logic [1:0] {
    KS_128  = 2'b00,
    KS_192  = 2'b01,
    KS_256  = 2'b10,
    KS_RSVD = 2'b11
  } key_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DONE   = 2'd3
  } ks_state_e;

  function automatic logic [3:0] ks_nk(input logic [1:0] ks);
    case (ks)
      KS_128:  return 4'd4;
      KS_192:  return 4'd6;
      KS_256:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] ks_nr(input logic [1:0] ks);
    case (ks)
      KS_128:  return 4'd10;
      KS_192:  return 4'd12;
      KS_256:  return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  // Words needed for the largest schedule this build supports: 4*(Nr+1) with Nr = Nk+6.
  function automatic int ks_store_depth(input int max_nk);
    return 4 * (max_nk + 7);
  endfunction

  function automatic logic [7:0] ks_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128/192/256 key schedule: one word per clock into a round-key store, indexed 128-bit read port.
// Define AES_KS_RKEY_REG_EN to register rk_out (one cycle behind rk_idx); otherwise rk_out is combinational.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; rejects reserved/unsupported key sizes
// ST_LOAD   | copy the latched key into words 0..Nk-1, seed i/j/rcon
// ST_EXPAND | derive one word w[i] per cycle up to w[4*Nr+3]
// ST_DONE   | one-cycle done pulse, schedule valid
module aes_key_schedule_seq
  import aes_ks_pkg::*;
#(
  parameter int MAX_NK = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [32*MAX_NK-1:0]  key_in,
  input  logic [1:0]            key_size,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [3:0]            rk_idx,
  output logic [127:0]          rk_out,
  output logic                  rk_valid
);

  localparam int DEPTH = ks_store_depth(MAX_NK);

  ks_state_e r_state, w_state_nxt;

  logic [32*MAX_NK-1:0]   r_key;
  logic [1:0]             r_ksize;
  logic [DEPTH-1:0][31:0] r_store;
  logic [5:0]             r_i;
  logic [2:0]             r_j;
  logic [7:0]             r_rcon;
  logic                   r_err;
  logic                   r_valid;

  logic [3:0]   w_nk, w_nr, w_nk_in, w_nk_m1;
  logic         w_reject, w_accept, w_last;
  logic [5:0]   w_prev_idx, w_back_idx, w_last_idx;
  logic [31:0]  w_prev, w_back, w_sub_in, w_sub_out, w_temp, w_new;
  logic [127:0] w_rk;

  assign w_nk       = ks_nk(r_ksize);
  assign w_nr       = ks_nr(r_ksize);
  assign w_nk_m1    = w_nk - 4'd1;
  assign w_nk_in    = ks_nk(key_size);
  assign w_reject   = start && ((key_size == KS_RSVD) || (int'(w_nk_in) > MAX_NK));
  assign w_accept   = start && !w_reject;
  assign w_last_idx = {w_nr, 2'b11};
  assign w_last     = (r_i == w_last_idx);
  assign w_prev_idx = r_i - 6'd1;
  assign w_back_idx = r_i - {2'b00, w_nk};

  // All store reads are compare-and-select so out-of-range indices simply read zero.
  always_comb begin
    w_prev = '0;
    w_back = '0;
    w_rk   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (6'(k) == w_prev_idx) w_prev = r_store[k];
      if (6'(k) == w_back_idx) w_back = r_store[k];
      for (int q = 0; q < 4; q++) begin
        if (6'(k) == {rk_idx, 2'(q)}) w_rk[127-32*q -: 32] = r_store[k];
      end
    end
    if (rk_idx > w_nr) w_rk = '0;
  end

  // One shared SubWord serves both the RotWord step (j==0) and the AES-256 mid-block step (j==4).
  assign w_sub_in = (r_j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (w_sub_in[8*g +: 8]),
      .o_byte (w_sub_out[8*g +: 8])
    );
  end

  always_comb begin
    w_temp = w_prev;
    if (r_j == 3'd0) begin
      w_temp = w_sub_out ^ {r_rcon, 24'h0};
    end else if ((w_nk == 4'd8) && (r_j == 3'd4)) begin
      w_temp = w_sub_out;
    end
  end

  assign w_new = w_back ^ w_temp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_LOAD;
      ST_LOAD:   w_state_nxt = ST_EXPAND;
      ST_EXPAND: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key   <= '0;
      r_ksize <= KS_128;
      r_store <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_rcon  <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_err <= (r_state == ST_IDLE) && w_reject;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_key   <= key_in;
            r_ksize <= key_size;
            r_valid <= 1'b0;
          end
        end
        ST_LOAD: begin
          for (int k = 0; k < MAX_NK; k++) begin
            if (k < int'(w_nk)) r_store[k] <= r_key[32*(MAX_NK-k)-1 -: 32];
          end
          r_i    <= {2'b00, w_nk};
          r_j    <= 3'd0;
          r_rcon <= 8'h01;
        end
        ST_EXPAND: begin
          for (int k = 0; k < DEPTH; k++) begin
            if (6'(k) == r_i) r_store[k] <= w_new;
          end
          r_i <= r_i + 6'd1;
          r_j <= ({1'b0, r_j} == w_nk_m1) ? 3'd0 : r_j + 3'd1;
          if (r_j == 3'd0) r_rcon <= ks_xtime(r_rcon);
          if (w_last) r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == ST_LOAD) || (r_state == ST_EXPAND);
  assign done     = (r_state == ST_DONE);
  assign err      = r_err;
  assign rk_valid = r_valid;

`ifdef AES_KS_RKEY_REG_EN
  logic [127:0] r_rk_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rk_out <= '0;
    else        r_rk_out <= w_rk;
  end

  assign rk_out = r_rk_out;
`else
  assign rk_out = w_rk;
`endif

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench for aes_key_schedule_seq: FIPS-197 vectors plus random keys against a
// behavioural key-expansion model whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_aes_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [255:0] key_in;
  logic [1:0]   key_size;
  logic         start;
  logic         busy, done, err, rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  logic [191:0] key_in6;
  logic [1:0]   key_size6;
  logic         start6;
  logic         busy6, done6, err6, rk_valid6;
  logic [3:0]   rk_idx6;
  logic [127:0] rk_out6;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  sbox_m [256];
  logic [7:0]  rcon_m [10];
  logic [31:0] mw [60];
  int          m_nr;

  always #5 clk = ~clk;

  aes_key_schedule_seq #(.MAX_NK(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_size(key_size), .start(start),
    .busy(busy), .done(done), .err(err), .rk_idx(rk_idx), .rk_out(rk_out), .rk_valid(rk_valid)
  );

  aes_key_schedule_seq #(.MAX_NK(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in6), .key_size(key_size6), .start(start6),
    .busy(busy6), .done(done6), .err(err6), .rk_idx(rk_idx6), .rk_out(rk_out6), .rk_valid(rk_valid6)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rcon_m[0] = 8'h01;
    for (int k = 1; k < 10; k++) rcon_m[k] = gmul(rcon_m[k-1], 8'h02);
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // FIPS-197 KeyExpansion with the textbook i mod Nk formulation.
  task automatic model_build(input logic [255:0] key, input int nk);
    logic [31:0] t;
    m_nr = nk + 6;
    for (int i = 0; i < 60; i++) mw[i] = 32'h0;
    for (int i = 0; i < nk; i++) mw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (m_nr + 1); i++) begin
      t = mw[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_m[i/nk-1], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int idx);
    if (idx > m_nr) return 128'h0;
    return {mw[4*idx], mw[4*idx+1], mw[4*idx+2], mw[4*idx+3]};
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic run_ks(input logic [255:0] key, input logic [1:0] ks, output int lat, output logic b0);
    @(negedge clk);
    key_in = key; key_size = ks; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b0 = busy;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic read_rk(input int idx, output logic [127:0] val);
    rk_idx = 4'(idx);
    @(negedge clk);
    val = rk_out;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rk_valid: got %b want 0", rk_valid); end
    n_checks++; if (rk_out !== 128'h0) begin n_fail++; $display("FAIL reset_rk_out: got %h want 0", rk_out); end
    n_checks++; if ({busy6, done6, err6, rk_valid6} !== 4'b0) begin n_fail++; $display("FAIL reset_dut6_flags: got %b want 0000", {busy6, done6, err6, rk_valid6}); end
    n_checks++; if (rk_out6 !== 128'h0) begin n_fail++; $display("FAIL reset_dut6_rk_out: got %h want 0", rk_out6); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_kat();
    logic [255:0] kkey [3];
    int           klat [3];
    int           kv_vec [5];
    int           kv_idx [5];
    logic [127:0] kv_val [5];
    int           lat;
    logic         b0;
    logic [127:0] got;
    kkey[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    kkey[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    kkey[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    klat[0] = 41; klat[1] = 47; klat[2] = 53;
    kv_vec[0] = 0; kv_idx[0] = 1;  kv_val[0] = 128'ha0fafe1788542cb123a339392a6c7605;
    kv_vec[1] = 0; kv_idx[1] = 10; kv_val[1] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    kv_vec[2] = 1; kv_idx[2] = 12; kv_val[2] = 128'he98ba06f448c773c8ecc720401002202;
    kv_vec[3] = 2; kv_idx[3] = 14; kv_val[3] = 128'hfe4890d1e6188d0b046df344706c631e;
    kv_vec[4] = 2; kv_idx[4] = 15; kv_val[4] = 128'h0;
    for (int v = 0; v < 3; v++) begin
      model_build(kkey[v], 4 + 2 * v);
      run_ks(kkey[v], 2'(v), lat, b0);
      n_checks++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL kat%0d_busy_after_start: got %b want 1", v, b0); end
      n_checks++; if (lat != klat[v]) begin n_fail++; $display("FAIL kat%0d_latency: got %0d want %0d", v, lat, klat[v]); end
      n_checks++; if (rk_valid !== 1'b1) begin n_fail++; $display("FAIL kat%0d_rk_valid_with_done: got %b want 1", v, rk_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kat%0d_busy_in_done: got %b want 0", v, busy); end
      @(negedge clk);
      n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL kat%0d_done_width: got done,busy=%b want 00", v, {done, busy}); end
      for (int p = 0; p < 5; p++) begin
        if (kv_vec[p] == v) begin
          read_rk(kv_idx[p], got);
          n_checks++; if (got !== kv_val[p]) begin n_fail++; $display("FAIL kat%0d_rk%0d: got %h want %h", v, kv_idx[p], got, kv_val[p]); end
        end
      end
      for (int idx = 0; idx < 16; idx++) begin
        read_rk(idx, got);
        n_checks++; if (got !== model_rk(idx)) begin n_fail++; $display("FAIL kat%0d_model_rk%0d: got %h want %h", v, idx, got, model_rk(idx)); end
      end
    end
  endtask

  task automatic test_random();
    logic [255:0] key;
    int           nk, lat;
    logic         b0;
    logic [127:0] got;
    for (int r = 0; r < 6; r++) begin
      key = rand_key();
      nk  = 4 + 2 * (r % 3);
      model_build(key, nk);
      run_ks(key, 2'(r % 3), lat, b0);
      n_checks++; if (lat != 4 * (m_nr + 1) - nk + 1) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", r, lat, 4 * (m_nr + 1) - nk + 1); end
      @(negedge clk);
      for (int idx = 0; idx < 16; idx++) begin
        read_rk(idx, got);
        n_checks++; if (got !== model_rk(idx)) begin n_fail++; $display("FAIL rand%0d_rk%0d: got %h want %h", r, idx, got, model_rk(idx)); end
      end
    end
  endtask

  task automatic test_reject_and_ignore();
    logic [127:0] got;
    logic [255:0] key_a;
    int           lat;
    // Reserved key size after a valid schedule (model still holds the last random run).
    @(negedge clk);
    key_in = rand_key(); key_size = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL reject_err_pulse: got %b want 1", err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reject_busy: got %b want 0", busy); end
    n_checks++; if (rk_valid !== 1'b1) begin n_fail++; $display("FAIL reject_rk_valid: got %b want 1", rk_valid); end
    @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reject_err_width: got %b want 0", err); end
    for (int idx = 0; idx < 16; idx++) begin
      read_rk(idx, got);
      n_checks++; if (got !== model_rk(idx)) begin n_fail++; $display("FAIL reject_rk%0d_kept: got %h want %h", idx, got, model_rk(idx)); end
    end
    // Second start pulsed mid-EXPAND with a different key and size must be ignored.
    key_a = rand_key();
    model_build(key_a, 4);
    @(negedge clk);
    key_in = key_a; key_size = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    repeat (10) begin @(negedge clk); lat++; end
    key_in = rand_key(); key_size = 2'b10; start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL busy_start_err: got %b want 0", err); end
    while (done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    n_checks++; if (lat != 41) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 41", lat); end
    @(negedge clk);
    for (int idx = 0; idx < 16; idx++) begin
      read_rk(idx, got);
      n_checks++; if (got !== model_rk(idx)) begin n_fail++; $display("FAIL busy_start_rk%0d: got %h want %h", idx, got, model_rk(idx)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] key_b;
    logic [127:0] got;
    int           lat;
    logic         b0;
    run_ks(rand_key(), 2'b00, lat, b0);
    key_b = rand_key();
    model_build(key_b, 6);
    // Now in the DONE cycle: a start here is ignored, the next IDLE cycle accepts it.
    key_in = key_b; key_size = 2'b01; start = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done_ignored: got busy=%b want 0", busy); end
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_start_in_idle_accepted: got busy=%b want 1", busy); end
    n_checks++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_rk_valid_cleared: got %b want 0", rk_valid); end
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    n_checks++; if (lat != 47) begin n_fail++; $display("FAIL b2b_latency: got %0d want 47", lat); end
    @(negedge clk);
    for (int idx = 0; idx < 16; idx++) begin
      read_rk(idx, got);
      n_checks++; if (got !== model_rk(idx)) begin n_fail++; $display("FAIL b2b_rk%0d: got %h want %h", idx, got, model_rk(idx)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] key;
    logic [127:0] got;
    int           lat;
    logic         b0;
    @(negedge clk);
    key_in = rand_key(); key_size = 2'b10; start = 1'b1;
    rk_idx = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL midreset_flags: got busy,done,err=%b want 000", {busy, done, err}); end
    n_checks++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_rk_valid: got %b want 0", rk_valid); end
    n_checks++; if (rk_out !== 128'h0) begin n_fail++; $display("FAIL midreset_rk_out: got %h want 0", rk_out); end
    @(negedge clk);
    rst_n = 1'b1;
    key = rand_key();
    model_build(key, 4);
    run_ks(key, 2'b00, lat, b0);
    n_checks++; if (lat != 41) begin n_fail++; $display("FAIL midreset_fresh_latency: got %0d want 41", lat); end
    @(negedge clk);
    for (int idx = 0; idx < 16; idx++) begin
      read_rk(idx, got);
      n_checks++; if (got !== model_rk(idx)) begin n_fail++; $display("FAIL midreset_fresh_rk%0d: got %h want %h", idx, got, model_rk(idx)); end
    end
  endtask

  task automatic test_read_latency();
    @(negedge clk);
    rk_idx = 4'd5;
    repeat (2) @(negedge clk);
    rk_idx = 4'd7;
    #1;
`ifdef AES_KS_RKEY_REG_EN
    n_checks++; if (rk_out !== model_rk(5)) begin n_fail++; $display("FAIL rkreg_holds_old: got %h want %h", rk_out, model_rk(5)); end
    @(negedge clk);
    n_checks++; if (rk_out !== model_rk(7)) begin n_fail++; $display("FAIL rkreg_updates_next: got %h want %h", rk_out, model_rk(7)); end
`else
    n_checks++; if (rk_out !== model_rk(7)) begin n_fail++; $display("FAIL rkcomb_immediate: got %h want %h", rk_out, model_rk(7)); end
`endif
  endtask

  task automatic test_max_nk6();
    logic [191:0] key6;
    logic         busy_seen;
    int           lat;
    @(negedge clk);
    key_in6 = rand_key()[255:64]; key_size6 = 2'b10; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    n_checks++; if (err6 !== 1'b1) begin n_fail++; $display("FAIL nk6_reject_err: got %b want 1", err6); end
    busy_seen = busy6;
    repeat (4) begin @(negedge clk); busy_seen = busy_seen | busy6; end
    n_checks++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL nk6_no_expansion: got busy seen=%b want 0", busy_seen); end
    n_checks++; if ({err6, rk_valid6} !== 2'b00) begin n_fail++; $display("FAIL nk6_after_reject: got err,rk_valid=%b want 00", {err6, rk_valid6}); end
    key6 = rand_key()[255:64];
    model_build({key6, 64'h0}, 6);
    key_in6 = key6; key_size6 = 2'b01; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    lat = 0;
    while (done6 !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    n_checks++; if (lat != 47) begin n_fail++; $display("FAIL nk6_192_latency: got %0d want 47", lat); end
    rk_idx6 = 4'd12;
    @(negedge clk);
    n_checks++; if (rk_out6 !== model_rk(12)) begin n_fail++; $display("FAIL nk6_192_rk12: got %h want %h", rk_out6, model_rk(12)); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    key_in = '0; key_size = 2'b00; start = 1'b0; rk_idx = 4'd0;
    key_in6 = '0; key_size6 = 2'b00; start6 = 1'b0; rk_idx6 = 4'd0;
    build_tables();
    test_reset();
    test_kat();
    test_random();
    test_reject_and_ignore();
    test_back_to_back();
    test_reset_mid();
    test_read_latency();
    test_max_nk6();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
